// File: rtl/bfm_ahbarbiter_pkg.sv
// Shared AHB encodings and helpers for the BFM bus arbiter.
// Imported by the arbiter, its picker and its interface.
package bfm_ahb_pkg;

    localparam int MAXMASTER = 8;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    // Beats in a burst minus one; INCR is open-ended so it counts as one.
    function automatic logic [3:0] burst_len(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            HB_WRAP4,  HB_INCR4:  len = 4'd3;
            HB_WRAP8,  HB_INCR8:  len = 4'd7;
            HB_WRAP16, HB_INCR16: len = 4'd15;
            default:              len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/bfm_ahbarbiter_if.sv
// AHB arbitration signals shared by the bus masters and the arbiter.
// The arbiter sits on the slave modport.
interface bfm_ahbarbiter_if #(
    parameter int NMASTER = 4
);
    logic [NMASTER-1:0] HBUSREQ;
    logic [NMASTER-1:0] HLOCK;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic               HREADY;
    logic [NMASTER-1:0] HGRANT;
    logic [2:0]         HMASTER;
    logic               HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/bfm_rr_pick.sv
// Combinational round-robin picker: first request at or after start,
// wrapping modulo N, falling back to the default index.
module bfm_rr_pick
    import bfm_ahb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [MAXMASTER-1:0] req,
    input  logic [2:0]           start,
    input  logic [2:0]           dflt,
    output logic [N-1:0]         gnt,
    output logic [2:0]           idx
);

    logic       found;
    logic [2:0] j;

    // Scan N slots from start; the earliest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = dflt;
        j     = start;
        for (int k = 0; k < N; k++) begin
            j = 3'((int'(start) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        gnt = N'(MAXMASTER'(1) << idx);
    end

endmodule

// File: rtl/bfm_ahbarbiter.sv
// AHB round-robin arbiter with burst tracking, locked-transfer hold
// and parking on a default master.
module bfm_ahbarbiter
    import bfm_ahb_pkg::*;
#(
    parameter int NMASTER   = 4,
    parameter int DEFMASTER = 0,
    parameter int TPD       = 1
) (
    input logic        HCLK,
    input logic        HRESETN,
    bfm_ahbarbiter_if.slave bus
);

    if (NMASTER < 2 || NMASTER > MAXMASTER ||
        DEFMASTER < 0 || DEFMASTER >= NMASTER || TPD < 0) begin : g_bad_param
        $error("bfm_ahbarbiter: parameter out of range");
    end

    localparam logic [NMASTER-1:0] RST_GNT = NMASTER'(1) << DEFMASTER;
    localparam logic [2:0]         DEF_IDX = 3'(DEFMASTER);

    logic [NMASTER-1:0]   grant_q, grant_d;
    logic [2:0]           gidx_q, gidx_d;
    logic [2:0]           mst_q, mst_d;
    logic                 mlock_q, mlock_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 unb_q, unb_d;

    logic [MAXMASTER-1:0] req8;
    logic [MAXMASTER-1:0] lock8;
    logic [2:0]           start;
    logic [NMASTER-1:0]   pick_gnt;
    logic [2:0]           pick_idx;
    logic                 arb;
    logic                 hold;

    assign req8  = MAXMASTER'(bus.HBUSREQ);
    assign lock8 = MAXMASTER'(bus.HLOCK);
    assign start = (mst_q == 3'(NMASTER - 1)) ? 3'd0 : mst_q + 3'd1;

    bfm_rr_pick #(
        .N(NMASTER)
    ) u_pick (
        .req  (req8),
        .start(start),
        .dflt (DEF_IDX),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Next-state: burst tracking, arbitration decision, ownership hand-over.
    always_comb begin
        cnt_d   = cnt_q;
        unb_d   = unb_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        mst_d   = mst_q;
        mlock_d = mlock_q;
        arb     = 1'b0;
        hold    = lock8[mst_q] && req8[mst_q];
        if (bus.HREADY) begin
            unique case (bus.HTRANS)
                HT_IDLE: begin
                    cnt_d = 4'd0;
                    unb_d = 1'b0;
                end
                HT_BUSY: begin
                    cnt_d = cnt_q;
                end
                HT_NONSEQ: begin
                    cnt_d = burst_len(bus.HBURST);
                    unb_d = (bus.HBURST == HB_INCR);
                end
                HT_SEQ: begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                end
            endcase
            arb = (bus.HTRANS == HT_IDLE) || unb_d || (cnt_d == 4'd0);
            mst_d   = gidx_q;
            mlock_d = lock8[gidx_q];
            if (arb) begin
                if (hold) begin
                    grant_d = NMASTER'(MAXMASTER'(1) << mst_q);
                    gidx_d  = mst_q;
                end else begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                end
            end
        end
    end

    // State and output registers; reset parks the bus on the default master.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            grant_q <= RST_GNT;
            gidx_q  <= DEF_IDX;
            mst_q   <= DEF_IDX;
            mlock_q <= 1'b0;
            cnt_q   <= 4'd0;
            unb_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            mst_q   <= mst_d;
            mlock_q <= mlock_d;
            cnt_q   <= cnt_d;
            unb_q   <= unb_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = mst_q;
    assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_bfm_ahbarbiter.sv
// Scoreboard bench for bfm_ahbarbiter: two instances (parking on 0 and 2)
// share stimulus and are checked against a transaction-level model.
module tb_bfm_ahbarbiter;
    import bfm_ahb_pkg::*;

    localparam int N = 4;

    typedef struct {
        int gnt;
        int own;
        bit lk;
        int left;
        bit unb;
    } arb_t;

    typedef struct {
        arb_t a;
        arb_t b;
    } exp_t;

    logic HCLK    = 1'b0;
    logic HRESETN = 1'b0;

    always #5 HCLK = ~HCLK;

    bfm_ahbarbiter_if #(.NMASTER(N)) bus_a ();
    bfm_ahbarbiter_if #(.NMASTER(N)) bus_b ();

    bfm_ahbarbiter #(.NMASTER(N), .DEFMASTER(0), .TPD(1)) dut_a (
        .HCLK   (HCLK),
        .HRESETN(HRESETN),
        .bus    (bus_a)
    );

    bfm_ahbarbiter #(.NMASTER(N), .DEFMASTER(2), .TPD(1)) dut_b (
        .HCLK   (HCLK),
        .HRESETN(HRESETN),
        .bus    (bus_b)
    );

    arb_t ma;
    arb_t mb;
    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int beats(input int hb);
        case (hb)
            2, 3:    return 4;
            4, 5:    return 8;
            6, 7:    return 16;
            default: return 1;
        endcase
    endfunction

    function automatic arb_t rst_state(input int defm);
        arb_t s;
        s.gnt = defm; s.own = defm; s.lk = 1'b0; s.left = 0; s.unb = 1'b0;
        return s;
    endfunction

    // One bus edge at transaction level: beats left, who owns, who is next.
    function automatic arb_t model_step(input arb_t s, input int req, input int lck,
                                        input int tr, input int hb, input bit rdy,
                                        input int defm);
        arb_t n;
        bit   arbp;
        n = s;
        if (!rdy) return s;
        case (tr)
            0: begin n.left = 0; n.unb = 1'b0; end
            2: begin n.left = beats(hb) - 1; n.unb = (hb == 1); end
            3: n.left = (s.left > 0) ? s.left - 1 : 0;
            default: ;
        endcase
        arbp  = (tr == 0) || n.unb || (n.left == 0);
        n.own = s.gnt;
        n.lk  = ((lck >> s.gnt) & 1) != 0;
        if (arbp) begin
            if ((((lck >> s.own) & 1) != 0) && (((req >> s.own) & 1) != 0)) begin
                n.gnt = s.own;
            end else begin
                n.gnt = defm;
                for (int k = N; k >= 1; k--)
                    if (((req >> ((s.own + k) % N)) & 1) != 0) n.gnt = (s.own + k) % N;
            end
        end
        return n;
    endfunction

    task automatic drive(input int req, input int lck, input int tr, input int hb, input bit rdy);
        bus_a.HBUSREQ = 4'(req); bus_b.HBUSREQ = 4'(req);
        bus_a.HLOCK   = 4'(lck); bus_b.HLOCK   = 4'(lck);
        bus_a.HTRANS  = 2'(tr);  bus_b.HTRANS  = 2'(tr);
        bus_a.HBURST  = 3'(hb);  bus_b.HBURST  = 3'(hb);
        bus_a.HREADY  = rdy;     bus_b.HREADY  = rdy;
    endtask

    // The owner of the current address phase acts like a simple BFM master.
    task automatic cyc(input int req, input int lck, input int hb, input bit rdy, input bit rnd);
        int   tr;
        exp_t x;
        @(negedge HCLK);
        if (ma.left > 0)
            tr = (rnd && $urandom_range(0, 5) == 0) ? 1 : 3;
        else if (ma.unb && rnd && $urandom_range(0, 1) == 1)
            tr = 3;
        else if (((req >> ma.own) & 1) != 0)
            tr = 2;
        else
            tr = 0;
        drive(req, lck, tr, hb, rdy);
        ma = model_step(ma, req, lck, tr, hb, rdy, 0);
        mb = model_step(mb, req, lck, tr, hb, rdy, 2);
        x.a = ma;
        x.b = mb;
        q.push_back(x);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_a_hgrant"},  32'(bus_a.HGRANT),  32'd1);
        check({tag, "_a_hmaster"}, 32'(bus_a.HMASTER), 32'd0);
        check({tag, "_a_hmastlock"}, 32'(bus_a.HMASTLOCK), 32'd0);
        check({tag, "_b_hgrant"},  32'(bus_b.HGRANT),  32'd4);
        check({tag, "_b_hmaster"}, 32'(bus_b.HMASTER), 32'd2);
        check({tag, "_b_hmastlock"}, 32'(bus_b.HMASTLOCK), 32'd0);
    endtask

    // Monitor: compare every pending expectation just after the edge.
    always @(posedge HCLK) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("a_hgrant",    32'(bus_a.HGRANT),    32'(1 << e.a.gnt));
            check("a_hmaster",   32'(bus_a.HMASTER),   32'(e.a.own));
            check("a_hmastlock", 32'(bus_a.HMASTLOCK), 32'(e.a.lk));
            check("b_hgrant",    32'(bus_b.HGRANT),    32'(1 << e.b.gnt));
            check("b_hmaster",   32'(bus_b.HMASTER),   32'(e.b.own));
            check("b_hmastlock", 32'(bus_b.HMASTLOCK), 32'(e.b.lk));
        end
    end

    initial begin
        ma = rst_state(0);
        mb = rst_state(2);
        drive(0, 0, 0, 0, 1'b1);
        #12;
        chk_reset("reset");
        @(negedge HCLK);
        HRESETN = 1'b1;

        // Two requesters, back-to-back SINGLEs.
        for (int i = 0; i < 16; i++) cyc(4'b1010, 0, HB_SINGLE, 1'b1, 1'b0);

        // INCR8 bursts with a three-cycle wait inside one of them.
        for (int i = 0; i < 40; i++)
            cyc(4'b1010, 0, HB_INCR8, !(i >= 8 && i <= 10), 1'b0);

        // Master 2 locked over SINGLEs, then the lock drops.
        for (int i = 0; i < 12; i++) cyc(4'b1111, 4'b0100, HB_SINGLE, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)  cyc(4'b1111, 0, HB_SINGLE, 1'b1, 1'b0);

        // Reset asynchronously in the middle of INCR4 traffic.
        for (int i = 0; i < 7; i++) cyc(4'b1111, 0, HB_INCR4, 1'b1, 1'b0);
        @(negedge HCLK);
        #2;
        HRESETN = 1'b0;
        #1;
        chk_reset("midburst_reset");
        ma = rst_state(0);
        mb = rst_state(2);
        drive(4'b1111, 0, 0, 0, 1'b1);
        @(posedge HCLK);
        #3;
        HRESETN = 1'b1;
        for (int i = 0; i < 10; i++) cyc(4'b1111, 0, HB_INCR4, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cyc(int'($urandom_range(0, 15)),
                int'($urandom & $urandom & $urandom & 32'hF),
                int'($urandom_range(0, 7)),
                $urandom_range(0, 4) != 0, 1'b1);

        @(negedge HCLK);
        @(negedge HCLK);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
